// File: rtl/jts16_obj_pkg.sv
// +--------------------------------------------------------------------------+
// | jts16_obj_pkg                                                            |
// | Object command layout and scheduler state encoding shared by the         |
// | scan, schedule and draw blocks.                                          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package jts16_obj_pkg;

  localparam int c_xpos_w   = 9;
  localparam int c_offset_w = 16;
  localparam int c_bank_w   = 3;
  localparam int c_prio_w   = 2;
  localparam int c_pal_w    = 6;
  localparam int c_cmd_w    = c_xpos_w + c_offset_w + c_bank_w + c_prio_w + c_pal_w;

  // Packed MSB-first as {xpos, offset, bank, prio, pal}
  typedef struct packed {
    logic [c_xpos_w-1:0]   xpos;
    logic [c_offset_w-1:0] offset;
    logic [c_bank_w-1:0]   bank;
    logic [c_prio_w-1:0]   prio;
    logic [c_pal_w-1:0]    pal;
  } obj_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/jts16_obj_sched_fifo.sv
// +--------------------------------------------------------------------------+
// | jts16_obj_sched_fifo                                                     |
// | In-order command queue with occupancy count and synchronous flush.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module jts16_obj_sched_fifo
  import jts16_obj_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  obj_cmd_t               wr_data,
  output obj_cmd_t               rd_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int               PW      = $clog2(DEPTH);
  localparam logic [PW:0]      c_depth = (PW+1)'(DEPTH);

  obj_cmd_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            push_ok;

  assign full    = (count_q == c_depth);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  // A pop in the same cycle frees the head slot, so a push into a full queue still lands.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/jts16_obj_sched.sv
// +--------------------------------------------------------------------------+
// | jts16_obj_sched                                                          |
// | Queues object commands from the scanner and dispatches them to the draw |
// | engine within a per-line cycle budget.                                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module jts16_obj_sched
  import jts16_obj_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [11:0] LINE_CYCLES = 12'd760
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hstart,
  input  logic        in_start,
  input  logic [8:0]  in_xpos,
  input  logic [15:0] in_offset,
  input  logic [2:0]  in_bank,
  input  logic [1:0]  in_prio,
  input  logic [5:0]  in_pal,
  output logic        in_busy,
  output logic        dr_start,
  output logic [8:0]  dr_xpos,
  output logic [15:0] dr_offset,
  output logic [2:0]  dr_bank,
  output logic [1:0]  dr_prio,
  output logic [5:0]  dr_pal,
  input  logic        dr_busy,
  output logic [7:0]  drop_cnt,
  output logic        late
);

  localparam int CW = $clog2(DEPTH) + 1;

  obj_cmd_t     in_cmd, head_cmd, cmd_q, cmd_d;
  logic         fifo_full, fifo_push, fifo_pop, dropped, expired;
  logic [CW-1:0] fifo_count;
  sched_state_e state_q, state_d;
  logic         dr_start_q, dr_start_d;
  logic [11:0]  budget_q, budget_d;
  logic [7:0]   drop_cnt_q, drop_cnt_d;

  assign in_cmd = '{xpos: in_xpos, offset: in_offset, bank: in_bank,
                    prio: in_prio, pal: in_pal};

  jts16_obj_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (hstart),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in_cmd),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign expired   = (budget_q >= LINE_CYCLES);
  assign fifo_push = in_start && !hstart;
  assign fifo_pop  = (state_q == ST_IDLE) && (fifo_count != '0) && !expired
                     && !dr_busy && !hstart;
  assign dropped   = fifo_push && fifo_full && !fifo_pop;

  always_comb begin
    state_d    = state_q;
    dr_start_d = fifo_pop;
    cmd_d      = fifo_pop ? head_cmd : cmd_q;
    budget_d   = hstart ? 12'd0 : ((budget_q == 12'hfff) ? budget_q : budget_q + 12'd1);
    drop_cnt_d = (dropped && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    if (hstart) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (fifo_pop) state_d = ST_START;
        ST_START: state_d = ST_GUARD;
        // The draw engine needs a cycle to raise dr_busy, so GUARD never samples it.
        ST_GUARD: state_d = ST_WAIT;
        ST_WAIT:  if (!dr_busy) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dr_start_q <= 1'b0;
      cmd_q      <= '0;
      budget_q   <= 12'hfff;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      dr_start_q <= dr_start_d;
      cmd_q      <= cmd_d;
      budget_q   <= budget_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dr_start  = dr_start_q && !hstart;
  assign dr_xpos   = cmd_q.xpos;
  assign dr_offset = cmd_q.offset;
  assign dr_bank   = cmd_q.bank;
  assign dr_prio   = cmd_q.prio;
  assign dr_pal    = cmd_q.pal;
  assign in_busy   = fifo_full;
  assign late      = expired && (fifo_count != '0);
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_jts16_obj_sched.sv
// +--------------------------------------------------------------------------+
// | tb_jts16_obj_sched                                                       |
// | Directed and randomized checks against a queue-based reference model.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_jts16_obj_sched;
  import jts16_obj_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [11:0] LINE  = 12'd40;

  logic        clk = 1'b0;
  logic        rst, hstart, in_start, dr_busy;
  logic [8:0]  in_xpos;
  logic [15:0] in_offset;
  logic [2:0]  in_bank;
  logic [1:0]  in_prio;
  logic [5:0]  in_pal;
  logic        in_busy, dr_start, late;
  logic [8:0]  dr_xpos;
  logic [15:0] dr_offset;
  logic [2:0]  dr_bank;
  logic [1:0]  dr_prio;
  logic [5:0]  dr_pal;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  jts16_obj_sched #(
    .DEPTH       (DEPTH),
    .LINE_CYCLES (LINE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hstart    (hstart),
    .in_start  (in_start),
    .in_xpos   (in_xpos),
    .in_offset (in_offset),
    .in_bank   (in_bank),
    .in_prio   (in_prio),
    .in_pal    (in_pal),
    .in_busy   (in_busy),
    .dr_start  (dr_start),
    .dr_xpos   (dr_xpos),
    .dr_offset (dr_offset),
    .dr_bank   (dr_bank),
    .dr_prio   (dr_prio),
    .dr_pal    (dr_pal),
    .dr_busy   (dr_busy),
    .drop_cnt  (drop_cnt),
    .late      (late)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int starts = 0;
  int last_start_cyc = -1;
  bit mon_en = 1'b0;

  // Reference model: queue contents, drop count, line budget, engine occupancy
  obj_cmd_t   mq[$];
  obj_cmd_t   exp_q[$];
  logic [8:0] seen_x[$];
  int         m_drop   = 0;
  int         m_budget = 4095;
  int         m_hold   = 0;
  bit         m_busy   = 1'b0;
  obj_cmd_t   mon_c;
  obj_cmd_t   dummy_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic obj_cmd_t rand_cmd();
    obj_cmd_t c;
    c.xpos   = 9'($urandom);
    c.offset = 16'($urandom);
    c.bank   = 3'($urandom);
    c.prio   = 2'($urandom);
    c.pal    = 6'($urandom);
    return c;
  endfunction

  function automatic obj_cmd_t cur_cmd();
    obj_cmd_t c;
    c.xpos = in_xpos; c.offset = in_offset; c.bank = in_bank;
    c.prio = in_prio; c.pal = in_pal;
    return c;
  endfunction

  // Applies the effect of one rising edge, using the inputs held during that cycle.
  task automatic model_edge();
    bit disp, was_full;
    cyc++;
    if (rst) begin
      mq.delete();
      m_drop = 0; m_budget = 4095; m_hold = 0; m_busy = 1'b0;
      return;
    end
    disp     = !m_busy && mq.size() > 0 && m_budget < int'(LINE) && !dr_busy && !hstart;
    was_full = (mq.size() == DEPTH);
    if (hstart) begin
      m_busy = 1'b0; m_hold = 0;
    end else if (disp) begin
      m_busy = 1'b1; m_hold = 2;
    end else if (m_busy) begin
      if (m_hold > 0) m_hold--;
      else if (!dr_busy) m_busy = 1'b0;
    end
    if (hstart) begin
      mq.delete();
    end else begin
      if (disp) exp_q.push_back(mq.pop_front());
      if (in_start) begin
        if (!was_full || disp) mq.push_back(cur_cmd());
        else if (m_drop < 255) m_drop++;
      end
    end
    m_budget = hstart ? 0 : ((m_budget < 4095) ? m_budget + 1 : 4095);
  endtask

  task automatic step(input bit hs, input bit push, input bit busy, input obj_cmd_t c);
    hstart = hs; in_start = push; dr_busy = busy;
    in_xpos = c.xpos; in_offset = c.offset; in_bank = c.bank;
    in_prio = c.prio; in_pal = c.pal;
    // A line start landing on the strobe cycle suppresses that strobe.
    if (hs && !rst && m_busy && m_hold == 2 && exp_q.size() > 0) dummy_c = exp_q.pop_back();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, busy, rand_cmd());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dr_start"}, dr_start, 0);
    check({tag, "_in_busy"}, in_busy, 0);
    check({tag, "_late"}, late, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_dr_fields"}, {dr_xpos, dr_offset, dr_bank, dr_prio, dr_pal}, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (dr_start === 1'b1) begin
        starts++;
        last_start_cyc = cyc;
        seen_x.push_back(dr_xpos);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dr_start: got dr_start=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_c = exp_q.pop_front();
          check("dr_fields", {dr_xpos, dr_offset, dr_bank, dr_prio, dr_pal}, mon_c);
        end
      end else if (exp_q.size() > 0) begin
        checks++; errors++;
        $display("FAIL missing_dr_start: got dr_start=%b expected 1 (cycle %0d)", dr_start, cyc);
        exp_q.delete();
      end
      check("in_busy", in_busy, (mq.size() == DEPTH) ? 1 : 0);
      check("drop_cnt", drop_cnt, m_drop);
      check("late", late, (m_budget >= int'(LINE) && mq.size() > 0) ? 1 : 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obj_cmd_t c;
    int p, s0, next_h;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
    check_reset_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic dispatch: two-cycle latency from push to strobe
    step(1'b1, 1'b0, 1'b0, '0);
    c = '{xpos: 9'h05a, offset: 16'h8123, bank: 3'd0, prio: 2'd0, pal: 6'h2a};
    s0 = starts;
    p  = cyc;
    step(1'b0, 1'b1, 1'b0, c);
    idle(5, 1'b0);
    check("basic_count", starts - s0, 1);
    check("basic_latency", last_start_cyc, p + 2);
    check("basic_fields", {dr_xpos, dr_offset, dr_pal}, {9'h05a, 16'h8123, 6'h2a});

    // Full queue: six pushes with the engine busy
    step(1'b1, 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      c = rand_cmd();
      c.xpos = 9'(i + 1);
      step(1'b0, 1'b1, 1'b1, c);
      if (i == 3) check("full_in_busy", in_busy, 1);
    end
    check("full_drop_cnt", drop_cnt, 2);
    s0 = starts;
    seen_x.delete();
    idle(24, 1'b0);
    check("full_dispatch_count", starts - s0, 4);
    for (int i = 0; i < 4; i++)
      check("full_order", (seen_x.size() > i) ? seen_x[i] : 9'h1ff, i + 1);

    // Budget expiry with two commands stuck behind a busy engine
    step(1'b1, 1'b0, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, rand_cmd());
    step(1'b0, 1'b1, 1'b1, rand_cmd());
    s0 = starts;
    idle(45, 1'b1);
    idle(5, 1'b0);
    check("budget_no_start", starts - s0, 0);
    check("budget_late", late, 1);
    step(1'b1, 1'b0, 1'b0, '0);
    check("budget_late_cleared", late, 0);
    idle(3, 1'b0);
    check("budget_flushed", starts - s0, 0);

    // Collisions: line start vs push, and push vs pop while full
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, rand_cmd());
    step(1'b1, 1'b1, 1'b1, rand_cmd());
    check("coll_hstart_busy", in_busy, 0);
    check("coll_hstart_drop", drop_cnt, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, rand_cmd());
    check("coll_fill_busy", in_busy, 1);
    step(1'b0, 1'b1, 1'b0, rand_cmd());
    check("coll_pushpop_busy", in_busy, 1);
    check("coll_pushpop_drop", drop_cnt, 2);
    idle(24, 1'b0);

    // Reset while waiting on the engine
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, rand_cmd());
    idle(1, 1'b0);
    idle(3, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, '0);
    rst = 1'b0;
    check_reset_outputs("midrst");
    s0 = starts;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, rand_cmd());
    check("midrst_no_start", starts - s0, 0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Randomized traffic with irregular line lengths
    next_h = cyc + int'($urandom_range(30, 70));
    for (int i = 0; i < 3000; i++) begin
      bit hs;
      hs = (cyc >= next_h);
      if (hs) next_h = cyc + int'($urandom_range(30, 70));
      step(hs, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, rand_cmd());
    end
    idle(20, 1'b0);
    check("drain_exp_empty", exp_q.size(), 0);
    check("random_activity", (starts > 50) ? 1 : 0, 1);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
